// File: rtl/lut_sweep_pkg.sv
// Shared types and constants for the lut_sweep truth-table sweeper.
package lut_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StSingle,
    StFin
  } state_e;

  localparam logic MODE_SWEEP  = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/lut_sel.sv
// LUT_W-to-1 read mux: returns the truth-table bit selected by index.
module lut_sel #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned LUT_W = 2 ** N_IN
) (
  input  logic [LUT_W-1:0] lut_bits,
  input  logic [N_IN-1:0]  index,
  output logic             bit_out
);

  assign bit_out = lut_bits[index];

endmodule

// File: rtl/lut_sweep.sv
// Programmable-truth-table evaluator: sweeps all input vectors or evaluates one,
// counting minterms, behind a start/busy/done handshake.
module lut_sweep
  import lut_sweep_pkg::*;
#(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned LUT_W = 2 ** N_IN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [LUT_W-1:0] lut,
  input  logic [N_IN-1:0]  vec_in,
  output logic             busy,
  output logic [N_IN-1:0]  vec_out,
  output logic             f_out,
  output logic             f_valid,
  output logic [N_IN:0]    ones_cnt,
  output logic             done
);

  localparam logic [N_IN-1:0] IdxLast = '1;

  state_e            state_q, state_d;
  logic [LUT_W-1:0]  lut_q;
  logic [N_IN-1:0]   vec_q;
  logic [N_IN-1:0]   idx_q;
  logic [N_IN-1:0]   sel_idx;
  logic              lut_bit;
  logic              accept;
  logic              emitting;

  logic              busy_q;
  logic [N_IN-1:0]   vec_out_q;
  logic              f_out_q;
  logic              f_valid_q;
  logic [N_IN:0]     ones_q;
  logic              done_q;

  assign accept   = (state_q == StIdle) && start;
  assign emitting = (state_q == StSweep) || (state_q == StSingle);
  assign sel_idx  = (state_q == StSingle) ? vec_q : idx_q;

  lut_sel #(
    .N_IN  (N_IN),
    .LUT_W (LUT_W)
  ) u_lut_sel (
    .lut_bits (lut_q),
    .index    (sel_idx),
    .bit_out  (lut_bit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (mode == MODE_SINGLE) ? StSingle : StSweep;
        end
      end
      StSweep: begin
        if (idx_q == IdxLast) begin
          state_d = StFin;
        end
      end
      StSingle: state_d = StFin;
      StFin:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      lut_q     <= '0;
      vec_q     <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      vec_out_q <= '0;
      f_out_q   <= 1'b0;
      f_valid_q <= 1'b0;
      ones_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_q == StFin);
      f_valid_q <= emitting;

      if (accept) begin
        lut_q  <= lut;
        vec_q  <= vec_in;
        idx_q  <= '0;
        ones_q <= '0;
      end

      // Index stops at the last vector rather than wrapping.
      if ((state_q == StSweep) && (idx_q != IdxLast)) begin
        idx_q <= idx_q + 1'b1;
      end

      if (emitting) begin
        vec_out_q <= sel_idx;
        f_out_q   <= lut_bit;
      end

      if (state_q == StSweep) begin
        ones_q <= ones_q + (N_IN + 1)'(lut_bit);
      end else if (state_q == StSingle) begin
        ones_q <= (N_IN + 1)'(lut_bit);
      end
    end
  end

  assign busy     = busy_q;
  assign vec_out  = vec_out_q;
  assign f_out    = f_out_q;
  assign f_valid  = f_valid_q;
  assign ones_cnt = ones_q;
  assign done     = done_q;

endmodule
